// File: rtl/axi_ram_arbiter.sv
// Two-requester round-robin front end for a single AXI4 RAM slave.
// Every accepted request turns into exactly one single-beat AXI read or write, one at a time.

module axi_ram_arbiter_rsp #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              hit_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= hit_i;
            if (load_i) rsp_rdata_o <= rdata_i;
        end
    end

endmodule

module axi_ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    input  logic [STRB_W-1:0] req0_wstrb_i,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_rdata_o,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    input  logic [STRB_W-1:0] req1_wstrb_i,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_rdata_o,

    output logic [ID_W-1:0]   axi_awid_o,
    output logic [ADDR_W-1:0] axi_awaddr_o,
    output logic [LEN_W-1:0]  axi_awlen_o,
    output logic [2:0]        axi_awsize_o,
    output logic [1:0]        axi_awburst_o,
    output logic              axi_awvalid_o,
    input  logic              axi_awready_i,

    output logic [DATA_W-1:0] axi_wdata_o,
    output logic [STRB_W-1:0] axi_wstrb_o,
    output logic              axi_wlast_o,
    output logic              axi_wvalid_o,
    input  logic              axi_wready_i,

    input  logic [ID_W-1:0]   axi_bid_i,
    input  logic [1:0]        axi_bresp_i,
    input  logic              axi_bvalid_i,
    output logic              axi_bready_o,

    output logic [ID_W-1:0]   axi_arid_o,
    output logic [ADDR_W-1:0] axi_araddr_o,
    output logic [LEN_W-1:0]  axi_arlen_o,
    output logic [2:0]        axi_arsize_o,
    output logic [1:0]        axi_arburst_o,
    output logic              axi_arvalid_o,
    input  logic              axi_arready_i,

    input  logic [ID_W-1:0]   axi_rid_i,
    input  logic [DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]        axi_rresp_i,
    input  logic              axi_rlast_i,
    input  logic              axi_rvalid_i,
    output logic              axi_rready_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;

    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              idx;
    } req_t;

    logic [2:0] state;
    logic       last_grant;
    req_t       cur;
    req_t       in_req;
    logic       aw_done;
    logic       w_done;

    logic [1:0] req_valid;
    logic       grant_any;
    logic       grant_idx;
    logic       accept;
    logic       aw_hs, w_hs, b_hs, r_hs;
    logic       aw_done_nxt, w_done_nxt;

    logic [1:0]             rsp_hit;
    logic [1:0]             rsp_load;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_W-1:0] rsp_rdata;

    // Ignored: the RAM answers in order and always OKAY.
    logic unused_inputs;
    assign unused_inputs = ^{axi_bid_i, axi_bresp_i, axi_rid_i, axi_rresp_i, axi_rlast_i};

    // Round robin: with both pending, the side that did not win last time goes.
    assign req_valid = {req1_valid_i, req0_valid_i};
    assign grant_any = |req_valid;
    assign grant_idx = (&req_valid) ? ~last_grant : req_valid[1];
    assign accept    = (state == S_IDLE) && grant_any && rst_n_i;

    assign req0_ready_o = accept && !grant_idx;
    assign req1_ready_o = accept &&  grant_idx;

    always_comb begin
        in_req       = '0;
        in_req.addr  = grant_idx ? req1_addr_i  : req0_addr_i;
        in_req.wdata = grant_idx ? req1_wdata_i : req0_wdata_i;
        in_req.wstrb = grant_idx ? req1_wstrb_i : req0_wstrb_i;
        in_req.idx   = grant_idx;
    end

    assign aw_hs = axi_awvalid_o && axi_awready_i;
    assign w_hs  = axi_wvalid_o  && axi_wready_i;
    assign b_hs  = axi_bready_o  && axi_bvalid_i;
    assign r_hs  = axi_rready_o  && axi_rvalid_i;

    assign aw_done_nxt = aw_done || aw_hs;
    assign w_done_nxt  = w_done  || w_hs;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cur        <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur        <= in_req;
                        last_grant <= grant_idx;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        state      <= (|in_req.wstrb) ? S_WR : S_RD_ADDR;
                    end
                end
                S_WR: begin
                    // AW and W retire independently, in either order.
                    if (aw_done_nxt && w_done_nxt) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= S_WR_RESP;
                    end else begin
                        aw_done <= aw_done_nxt;
                        w_done  <= w_done_nxt;
                    end
                end
                S_WR_RESP: if (axi_bvalid_i)  state <= S_IDLE;
                S_RD_ADDR: if (axi_arready_i) state <= S_RD_DATA;
                S_RD_DATA: if (axi_rvalid_i)  state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign axi_awid_o    = {{(ID_W-1){1'b0}}, cur.idx};
    assign axi_awaddr_o  = cur.addr;
    assign axi_awlen_o   = '0;
    assign axi_awsize_o  = AXSIZE;
    assign axi_awburst_o = BURST_INCR;
    assign axi_awvalid_o = (state == S_WR) && !aw_done;

    assign axi_wdata_o   = cur.wdata;
    assign axi_wstrb_o   = cur.wstrb;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = (state == S_WR) && !w_done;

    assign axi_bready_o  = (state == S_WR_RESP);

    assign axi_arid_o    = {{(ID_W-1){1'b0}}, cur.idx};
    assign axi_araddr_o  = cur.addr;
    assign axi_arlen_o   = '0;
    assign axi_arsize_o  = AXSIZE;
    assign axi_arburst_o = BURST_INCR;
    assign axi_arvalid_o = (state == S_RD_ADDR);

    assign axi_rready_o  = (state == S_RD_DATA);

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        assign rsp_hit[i]  = (b_hs || r_hs) && (cur.idx == 1'(i));
        assign rsp_load[i] = r_hs && (cur.idx == 1'(i));

        axi_ram_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .hit_i       (rsp_hit[i]),
            .load_i      (rsp_load[i]),
            .rdata_i     (axi_rdata_i),
            .rsp_valid_o (rsp_valid[i]),
            .rsp_rdata_o (rsp_rdata[i])
        );
    end

    assign rsp0_valid_o = rsp_valid[0];
    assign rsp1_valid_o = rsp_valid[1];
    assign rsp0_rdata_o = rsp_rdata[0];
    assign rsp1_rdata_o = rsp_rdata[1];

endmodule
